// File: rtl/maxpool_pkg.sv
// Shared types and constants for the maxpool
// datapath and its channel sequencer.
package maxpool_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    NEXT,
    FINISH
  } mp_seq_state_t;

  function automatic int clog2_min1(
    input int v
  );
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/maxpool_out_capture.sv
// Pooled-output capture: counts outputs,
// forms channel-linear write addresses.
module maxpool_out_capture #(
  parameter int OUT_PIX = 196,
  parameter int CH_W    = 3,
  parameter int OUT_AW  = 11,
  parameter int DW      = 8,
  parameter int OC_W    =
    maxpool_pkg::clog2_min1(OUT_PIX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_data,
  input  logic [CH_W-1:0]   i_ch,
  output logic              o_wr_en,
  output logic [OUT_AW-1:0] o_wr_addr,
  output logic [DW-1:0]     o_wr_data,
  output logic [OC_W-1:0]   o_ocnt,
  output logic              o_ovf
);
  import maxpool_pkg::*;

  logic [OC_W-1:0]   r_ocnt;
  logic              r_wr_en;
  logic [OUT_AW-1:0] r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic              w_full;
  logic              w_take;
  logic [OUT_AW-1:0] w_addr;

  assign w_full = (r_ocnt == OC_W'(OUT_PIX));
  assign w_take = i_en & i_valid;
  assign w_addr = OUT_AW'(i_ch) * OUT_AW'(OUT_PIX)
                + OUT_AW'(r_ocnt);

  // channel is sampled with the data, so late
  // writes keep the channel they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ocnt    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (i_clr) begin
        r_ocnt <= '0;
      end else if (w_take && !w_full) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_addr;
        r_wr_data <= i_data;
        r_ocnt    <= r_ocnt + OC_W'(1);
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_ocnt    = r_ocnt;
  assign o_ovf     = w_take & w_full;

endmodule

// File: rtl/maxpool_channel_sequencer.sv
// Runs one maxpool engine over every channel
// of a layer, with per-channel watchdog.
module maxpool_channel_sequencer #(
  parameter int MAP_WIDTH    = 28,
  parameter int NUM_CHANNELS = 6,
  parameter int DATA_W       = maxpool_pkg::DATA_W,
  parameter int WATCHDOG     = 500,
  parameter int IN_AW        =
    $clog2(NUM_CHANNELS * MAP_WIDTH * MAP_WIDTH),
  parameter int OUT_AW       =
    $clog2(NUM_CHANNELS * (MAP_WIDTH / 2)
           * (MAP_WIDTH / 2))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              eng_rst,
  output logic              eng_valid_in,
  output logic [DATA_W-1:0] eng_pixel_in,
  input  logic              eng_valid_out,
  input  logic [DATA_W-1:0] eng_pixel_out,
  input  logic              eng_all_done,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);
  import maxpool_pkg::*;

  localparam int PIX     = MAP_WIDTH * MAP_WIDTH;
  localparam int OUT_W   = MAP_WIDTH / 2;
  localparam int OUT_PIX = OUT_W * OUT_W;
  localparam int PW      = clog2_min1(PIX);
  localparam int CW      = clog2_min1(NUM_CHANNELS);
  localparam int WW      = clog2_min1(WATCHDOG + 1);
  localparam int OCW     = clog2_min1(OUT_PIX + 1);

  mp_seq_state_t r_state;
  mp_seq_state_t w_next;

  logic           r_clr_cnt;
  logic [PW-1:0]  r_pix;
  logic [WW-1:0]  r_wd;
  logic [CW-1:0]  r_ch;
  logic           r_err;
  logic           r_vin;

  logic           w_last_pix;
  logic [WW-1:0]  w_wd_inc;
  logic           w_wd_hit;
  logic           w_last_ch;
  logic [OCW-1:0] w_ocnt;
  logic           w_ovf;
  logic           w_cap_en;

  assign w_last_pix = (r_pix == PW'(PIX - 1));
  assign w_wd_inc   = r_wd + WW'(1);
  assign w_wd_hit   = (w_wd_inc == WW'(WATCHDOG));
  assign w_last_ch  = (r_ch == CW'(NUM_CHANNELS - 1));
  assign w_cap_en   = (r_state == FEED)
                    | (r_state == DRAIN)
                    | (r_state == NEXT);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = CLEAR;
      CLEAR:  if (r_clr_cnt) w_next = FEED;
      FEED:   if (w_last_pix) w_next = DRAIN;
      DRAIN:  begin
        if (eng_all_done || w_wd_hit)
          w_next = NEXT;
      end
      NEXT:   w_next = w_last_ch ? FINISH : CLEAR;
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clr_cnt <= 1'b0;
      r_pix     <= '0;
      r_wd      <= '0;
      r_ch      <= '0;
      r_err     <= 1'b0;
      r_vin     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vin   <= (r_state == FEED);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ch  <= '0;
            r_err <= 1'b0;
          end
        end
        CLEAR: begin
          r_clr_cnt <= ~r_clr_cnt;
          r_pix     <= '0;
          r_wd      <= '0;
        end
        FEED: begin
          if (!w_last_pix)
            r_pix <= r_pix + PW'(1);
        end
        DRAIN: begin
          r_wd <= w_wd_inc;
          // completion wins over a same-cycle timeout
          if (!eng_all_done && w_wd_hit)
            r_err <= 1'b1;
        end
        NEXT: begin
          r_ch <= r_ch + CW'(1);
          if (w_ocnt != OCW'(OUT_PIX))
            r_err <= 1'b1;
        end
        default: ;
      endcase
      if (w_ovf)
        r_err <= 1'b1;
    end
  end

  maxpool_out_capture #(
    .OUT_PIX (OUT_PIX),
    .CH_W    (CW),
    .OUT_AW  (OUT_AW),
    .DW      (DATA_W),
    .OC_W    (OCW)
  ) u_cap (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == CLEAR),
    .i_en      (w_cap_en),
    .i_valid   (eng_valid_out),
    .i_data    (eng_pixel_out),
    .i_ch      (r_ch),
    .o_wr_en   (out_wr_en),
    .o_wr_addr (out_wr_addr),
    .o_wr_data (out_wr_data),
    .o_ocnt    (w_ocnt),
    .o_ovf     (w_ovf)
  );

  assign busy = (r_state == CLEAR)
              | (r_state == FEED)
              | (r_state == DRAIN)
              | (r_state == NEXT);
  assign done = (r_state == FINISH);
  assign error = r_err;
  assign in_rd_en = (r_state == FEED);
  assign in_rd_addr = IN_AW'(r_ch) * IN_AW'(PIX)
                    + IN_AW'(r_pix);
  assign eng_rst = rst | (r_state == CLEAR);
  assign eng_valid_in = r_vin;
  assign eng_pixel_in = in_rd_data;

endmodule

// File: tb/tb_maxpool_channel_sequencer.sv
// Scoreboard bench for the channel sequencer
// with a behavioural 4x4 maxpool engine.
module tb_maxpool_channel_sequencer;

  localparam int MW  = 4;
  localparam int NC  = 3;
  localparam int DW  = 8;
  localparam int WDG = 20;
  localparam int IAW = 6;
  localparam int OAW = 4;

  localparam int M_NORM = 0;
  localparam int M_WD   = 1;
  localparam int M_OVF  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           busy, done, error;
  logic           in_rd_en;
  logic [IAW-1:0] in_rd_addr;
  logic [DW-1:0]  in_rd_data = '0;
  logic           eng_rst, eng_valid_in;
  logic [DW-1:0]  eng_pixel_in;
  logic           eng_valid_out = 1'b0;
  logic [DW-1:0]  eng_pixel_out = '0;
  logic           eng_all_done = 1'b0;
  logic           out_wr_en;
  logic [OAW-1:0] out_wr_addr;
  logic [DW-1:0]  out_wr_data;

  maxpool_channel_sequencer #(
    .MAP_WIDTH    (MW),
    .NUM_CHANNELS (NC),
    .DATA_W       (DW),
    .WATCHDOG     (WDG),
    .IN_AW        (IAW),
    .OUT_AW       (OAW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .in_rd_en      (in_rd_en),
    .in_rd_addr    (in_rd_addr),
    .in_rd_data    (in_rd_data),
    .eng_rst       (eng_rst),
    .eng_valid_in  (eng_valid_in),
    .eng_pixel_in  (eng_pixel_in),
    .eng_valid_out (eng_valid_out),
    .eng_pixel_out (eng_pixel_out),
    .eng_all_done  (eng_all_done),
    .out_wr_en     (out_wr_en),
    .out_wr_addr   (out_wr_addr),
    .out_wr_data   (out_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t sb[$];
  logic [DW-1:0] mem [NC*MW*MW];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = M_NORM;
  int exp_drain = 2;
  int exp_rd = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int last_rd = 0;
  bit pend = 1'b0;
  logic prev_vo = 1'b0;
  logic prev_erst = 1'b0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int smax(input int a,
                              input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int px(input int i);
    logic signed [DW-1:0] v;
    v = mem[i];
    return int'(v);
  endfunction

  function automatic int gold(input int ch,
                              input int oy,
                              input int ox);
    int b;
    b = ch * MW * MW + 2 * oy * MW + 2 * ox;
    return smax(smax(px(b), px(b + 1)),
                smax(px(b + MW), px(b + MW + 1)));
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_rd_en)
      in_rd_data <= mem[in_rd_addr];
  end

  // behavioural engine: raster input, 2x2 max
  logic signed [DW-1:0] e_px [MW*MW];
  logic [3:0] e_n = '0;
  int e_emit = 0;

  always @(posedge clk) begin
    if (eng_rst) begin
      e_n <= '0;
      e_emit <= 0;
      eng_valid_out <= 1'b0;
      eng_all_done <= 1'b0;
    end else begin
      eng_valid_out <= 1'b0;
      if (eng_valid_in) begin
        e_px[e_n] <= eng_pixel_in;
        e_n <= e_n + 4'd1;
        if (e_n[2] && e_n[0]) begin
          eng_valid_out <= 1'b1;
          eng_pixel_out <= DW'(smax(
            smax(int'(e_px[e_n - 4'd5]),
                 int'(e_px[e_n - 4'd4])),
            smax(int'(e_px[e_n - 4'd1]),
                 int'($signed(eng_pixel_in)))));
          e_emit <= e_emit + 1;
          if (e_emit == 3 && mode == M_NORM)
            eng_all_done <= 1'b1;
        end
      end else if (mode == M_OVF && e_emit == 4) begin
        eng_valid_out <= 1'b1;
        eng_pixel_out <= 8'd99;
        e_emit <= 5;
        eng_all_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (in_rd_en) begin
      chk("rd_addr", in_rd_addr, exp_rd);
      exp_rd++;
      rd_cnt++;
      if (int'(in_rd_addr) % (MW * MW) == MW * MW - 1) begin
        pend = 1'b1;
        last_rd = cyc;
      end
    end
    if (pend && ((eng_rst && !prev_erst) || done)) begin
      chk("drain_gap", cyc - last_rd, exp_drain + 2);
      pend = 1'b0;
    end
    if (done)
      done_cnt++;
    if (out_wr_en) begin
      chk("wr_latency", prev_vo, 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_extra: got addr %0d expected none",
                 out_wr_addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", out_wr_addr, e.addr);
        chk("wr_data", $signed(out_wr_data), e.data);
      end
    end
    prev_vo = eng_valid_out;
    prev_erst = eng_rst;
  end

  task automatic run_case(input int m,
                          input int inj_start,
                          input int inj_rst,
                          input int exp_d,
                          input bit exp_err,
                          input string tag);
    bit got;
    wr_t w;
    mode = m;
    exp_drain = exp_d;
    exp_rd = 0;
    rd_cnt = 0;
    done_cnt = 0;
    pend = 1'b0;
    for (int c = 0; c < NC; c++)
      for (int y = 0; y < MW / 2; y++)
        for (int x = 0; x < MW / 2; x++) begin
          w.addr = c * 4 + y * 2 + x;
          w.data = gold(c, y, x);
          sb.push_back(w);
        end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_erst_t1"}, eng_rst, 1);
    chk({tag, "_err_clr"}, error, 0);
    @(posedge clk); #1;
    chk({tag, "_rd_t2"}, in_rd_en, 0);
    @(posedge clk); #1;
    chk({tag, "_rd_t3"}, in_rd_en, 1);
    chk({tag, "_vin_t3"}, eng_valid_in, 0);
    @(posedge clk); #1;
    chk({tag, "_vin_t4"}, eng_valid_in, 1);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inj_start >= 0 && rd_cnt == inj_start) begin
        start = 1'b1;
        inj_start = -1;
      end
      if (inj_rst >= 0 && rd_cnt == inj_rst) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"}, in_rd_en, 0);
        chk({tag, "_wr"}, out_wr_en, 0);
        sb.delete();
        pend = 1'b0;
        return;
      end
      if (done) begin
        got = 1'b1;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_reads"}, rd_cnt, NC * MW * MW);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < NC * MW * MW; i++)
      mem[i] = DW'(i * 37 + 11);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_flags",
        {busy, done, error, in_rd_en,
         eng_valid_in, out_wr_en}, 0);
    chk("rst_addrs",
        {in_rd_addr, out_wr_addr, out_wr_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_eng_rst", eng_rst, 0);
    chk("idle_busy", busy, 0);

    run_case(M_NORM, -1, -1, 2, 1'b0, "nom");
    run_case(M_NORM, 26, -1, 2, 1'b0, "busy_start");
    run_case(M_WD, -1, -1, WDG, 1'b1, "wdog");
    run_case(M_OVF, -1, -1, 3, 1'b1, "ovf");

    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    chk("rst_vs_start", busy, 0);
    chk("rst_err_clr", error, 0);
    @(posedge clk); #1;
    chk("rst_vs_start2", busy, 0);

    mode = M_NORM;
    run_case(M_NORM, -1, 35, 2, 1'b0, "midrst");
    run_case(M_NORM, -1, -1, 2, 1'b0, "restart");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
